// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and frame data width.
// Used by the transmitter and the bit-timing counter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 39;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_STOP   = 3'b011,
    ST_PARITY = 3'b100
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear_i is high, so a new bit period starts cleanly.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;

  assign bit_end_o = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || bit_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, idle-high line driven from a register.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (0)
// DATA   | data bits 0..7
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (1), done pulse on its last cycle
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              bit_end;

  // The counter idles at zero so the start bit gets a full period from the accepting edge.
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == ST_IDLE),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          idx_q  <= '0;
          if (tx_start) begin
            shift_q <= din;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= ^shift_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter at CLKS_PER_BIT=4: the driver queues expected
// bytes, an independent line monitor decodes each frame cycle by cycle and compares.
module tb_uart_transmitter;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, tx_busy, tx_done_tick;

  int checks = 0;
  int errors = 0;
  int frames_sent = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7];
`endif
    return 1'b1;
  endfunction

  // Entered at the sample point just after the accepting edge (start bit seen low).
  task automatic run_frame();
    logic [7:0] b;
    int bad;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 1, 0);
      b = 8'h00;
    end else begin
      b = exp_q.pop_front();
    end
    frames_seen++;
    for (int k = 0; k < NBITS; k++) begin
      bad = 0;
      for (int j = 0; j < C; j++) begin
        if (k != 0 || j != 0) begin
          @(posedge clk); #2;
        end
        if (!rst_n) return;
        if (tx !== exp_bit(b, k) || tx_busy !== 1'b1 || tx_done_tick !== 1'b0) bad++;
      end
      check($sformatf("frame_%02h_bit%0d_bad_cycles", b, k), bad, 0);
    end
    @(posedge clk); #2;
    if (!rst_n) return;
    check($sformatf("frame_%02h_done_busy", b), {30'd0, tx_done_tick, tx_busy}, 32'b10);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk); #2;
      if (rst_n) begin
        if (tx_done_tick) check("spurious_done", 1, 0);
        while (rst_n && tx === 1'b0) run_frame();
      end
    end
  end

  // Called #1 after an edge; returns #1 after the accepting edge E0.
  task automatic start_byte(input logic [7:0] b);
    din = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    frames_sent++;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cycles, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tx_done_tick && n < 500);
    check(name, n, exp_cycles);
  endtask

  initial begin : driver
    int bad;
    int dones;
    logic [7:0] vec[4];
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h81; vec[3] = 8'h07;

    @(posedge clk); #1;
    check("reset_vals", {29'd0, tx, tx_busy, tx_done_tick}, 32'b100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
    end
    check("idle_100_bad_cycles", bad, 0);

    start_byte(8'h55);
    check("accept_no_latency", {30'd0, tx, tx_busy}, 32'b01);
    wait_done(FL, "done_55_cycle");
    repeat (5) @(posedge clk); #1;

    start_byte(8'hA5);
    wait_done(FL, "done_a5_cycle");
    start_byte(8'h3C);
    check("b2b_no_gap", {30'd0, tx, tx_busy}, 32'b01);
    wait_done(FL, "done_3c_cycle");
    repeat (5) @(posedge clk); #1;

    start_byte(8'hFF);
    repeat (11) @(posedge clk); #1;
    din = 8'h00;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_done(FL - 12, "done_ff_cycle");
    dones = 0;
    repeat (2 * FL) begin
      @(posedge clk); #1;
      if (tx_done_tick) dones++;
    end
    check("busy_start_ignored_dones", dones, 0);

    start_byte(8'h96);
    repeat (16) @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check("async_reset_line", {29'd0, tx, tx_busy, tx_done_tick}, 32'b100);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("abort_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    start_byte(8'h96);
    wait_done(FL, "done_96_after_reset");

    for (int i = 0; i < 4; i++) begin
      start_byte(vec[i]);
      wait_done(FL, $sformatf("done_%02h_cycle", vec[i]));
    end
    for (int i = 0; i < 8; i++) begin
      start_byte(8'($urandom_range(0, 255)));
      wait_done(FL, "done_rand_cycle");
    end

    repeat (FL) @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);
    check("frames_seen", frames_seen, frames_sent);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter, 8N1 framing, LSB first, one start bit (0) and one stop bit (1). It is the transmit counterpart of the UART receiver in the same UART component. It shares the receiver's CLKS_PER_BIT bit timing, so a transmitter/receiver pair with equal parameters forms a loopback link. It accepts one byte per start request from the CPU-side logic and drives the idle-high serial line.

## Interface
- CLKS_PER_BIT, 39, clk cycles per serial bit; legal range 2..255.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send din; sampled only in IDLE.
- din  input  8  byte to send; captured on the accepting edge.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high from the accepting edge until the frame ends.
- tx_done_tick  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, STOP, plus PARITY under UART_TX_PARITY_EN.
- IDLE:
  - tx=1, busy=0, bit counter and bit index cleared.
  - If tx_start=1, latch din into shift register, go to START, busy<=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA:
  - tx=shift[index] for CLKS_PER_BIT cycles per bit.
  - Index 0..7 (3-bit), no wrap; after bit 7, go to STOP (or PARITY).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle, go to IDLE, tx_done_tick<=1, busy<=0.
- Bit counter: width 8, counts 0..CLKS_PER_BIT-1, resets to 0 at every bit boundary.
- din changes after acceptance are ignored; the frame always sends the latched byte.
- tx_start while busy=1 is ignored: not queued, no error flag.
- Illegal state encoding goes to IDLE with tx=1.
- Reset:
  - Reset values: tx=1, tx_busy=0, tx_done_tick=0, state IDLE, counters 0, shift register 0.
  - Reset mid-frame aborts immediately; the line returns high asynchronously.

## Timing
- Accepting edge E0: tx_start=1 and state IDLE.
- After E0: tx=0, tx_busy=1. No extra latency cycle.
- Data bit k occupies edges E0+(1+k)·C to E0+(2+k)·C, where C=CLKS_PER_BIT.
- Stop bit occupies E0+9C to E0+10C.
- At E0+10C:
  - state IDLE, tx_busy=0, tx_done_tick=1 for exactly one cycle.
  - Frame length is 10C cycles (11C with parity).
- Back-to-back: tx_start=1 in the cycle where tx_done_tick=1 (busy=0) is accepted on that edge. The next start bit follows with no idle gap.
- tx_done_tick never asserts without a completed stop bit.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows bit 7.
  - tx = XOR of the 8 latched bits (even parity) for C cycles, then STOP.
  - Frame is 11C cycles.
- Undefined:
  - No PARITY state.
  - Frame is 10C cycles, compatible with the existing receiver.

## Structure
- Shared package uart_pkg contains:
  - state encoding constants (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, PARITY=3'b100);
  - the default CLKS_PER_BIT;
  - the frame data width (8).
- The receiver migrates to the same package.
- One sub-module: uart_baud_counter.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear.
  - Outputs: bit_end, high on the last cycle of a bit.
  - Reused later by the receiver.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated.

- Reset then idle: rst_n low 3 cycles, then released, no start → tx=1, busy=0, done=0 for 100 cycles.
- Single byte 0x55, start pulse at E0 → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; done pulse exactly at E0+40; busy high for 40 cycles.
- Back-to-back 0xA5 then 0x3C, second start asserted in the done cycle → 80 contiguous cycles with no idle gap; two done pulses 40 cycles apart.
- Start and din change while busy: start 0xFF, pulse start with din=0x00 at E0+12 → only 0xFF is sent; a single done pulse.
- Async reset at E0+17 mid-frame → tx=1 and busy=0 before the next edge; the next start sends a clean full frame.
- Loopback with the receiver at CLKS_PER_BIT=39, bytes 0x00, 0xFF, 0x81, random ×50 → receiver dout matches each byte; one Rx_done_tick per frame. With UART_TX_PARITY_EN, 0x07 gives parity bit 1 and an 11C frame.
